// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants.
package mips_pkg;

    localparam int unsigned INSTR_W      = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h00000000;
    localparam logic [31:0] RESET_PC_DEF = 32'h00000000;

endpackage

// File: rtl/i_fetch_imem.sv
// Instruction memory: one synchronous write port, one combinational read port.
module i_fetch_imem
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 128,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [INSTR_W-1:0]   i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr,
    output logic [INSTR_W-1:0]   o_rdata
);

    // Contents are deliberately not reset; boot logic loads them.
    logic [INSTR_W-1:0] r_mem [IMEM_DEPTH];

    // Write port; a same-cycle read of the written word still sees the old value.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/i_fetch.sv
// MIPS IF stage: PC register, next-PC selection and the IF/ID pipeline register.
module i_fetch
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 128,
    parameter int unsigned ADDR_W     = 7,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 PCSrc,
    input  logic [31:0]          EX_MEM_NPC,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 imem_we,
    input  logic [ADDR_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0]   imem_wdata,
    output logic [INSTR_W-1:0]   IF_ID_instr,
    output logic [31:0]          IF_ID_NPC,
    output logic                 IF_ID_valid,
    output logic [31:0]          PC
);

    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_npc;
    logic               r_valid;

    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_pc_next;
    logic [ADDR_W-1:0]  w_rd_idx;
    logic [INSTR_W-1:0] w_fetch;
    logic               w_unused_bits;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_rd_idx   = r_pc[ADDR_W+1:2];
    // PC bits outside the word index and the target's byte offset are don't-care.
    assign w_unused_bits = ^{r_pc[31:ADDR_W+2], r_pc[1:0], EX_MEM_NPC[1:0]};

    i_fetch_imem #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_imem (
        .clk     (clk),
        .i_we    (imem_we),
        .i_waddr (imem_waddr),
        .i_wdata (imem_wdata),
        .i_raddr (w_rd_idx),
        .o_rdata (w_fetch)
    );

    // Next PC: a redirect overrides stall.
    always_comb begin
        w_pc_next = w_pc_plus4;
        if (PCSrc) begin
            w_pc_next = {EX_MEM_NPC[31:2], 2'b00};
        end else if (stall) begin
            w_pc_next = r_pc;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID register: flush inserts a bubble and overrides stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr <= NOP_INSTR;
            r_npc   <= 32'd0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_instr <= NOP_INSTR;
            r_npc   <= 32'd0;
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr <= w_fetch;
            r_npc   <= w_pc_plus4;
            r_valid <= 1'b1;
        end
    end

    assign IF_ID_instr = r_instr;
    assign IF_ID_NPC   = r_npc;
    assign IF_ID_valid = r_valid;
    assign PC          = r_pc;

endmodule

// File: tb/tb_i_fetch.sv
// Self-checking bench for i_fetch: directed sequence plus randomized traffic.
module tb_i_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc;
    logic [31:0] EX_MEM_NPC;
    logic        stall;
    logic        flush;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_NPC;
    logic        IF_ID_valid;
    logic [31:0] PC;

    i_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSrc       (PCSrc),
        .EX_MEM_NPC  (EX_MEM_NPC),
        .stall       (stall),
        .flush       (flush),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_NPC   (IF_ID_NPC),
        .IF_ID_valid (IF_ID_valid),
        .PC          (PC)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference model.
    logic [31:0] m_mem [128];
    logic [31:0] m_pc, m_instr, m_npc;
    logic        m_valid;
    bit          m_known = 1'b0;

    // Initial image; kept separately so directed checks can name old words.
    logic [31:0] img [128];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] fetched;
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            m_known = 1'b1;
        end else begin
            fetched = m_mem[(m_pc / 4) % 128];
            if (flush) begin
                m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = fetched; m_npc = m_pc + 32'd4; m_valid = 1'b1;
            end
            if (PCSrc)       m_pc = EX_MEM_NPC & 32'hFFFFFFFC;
            else if (!stall) m_pc = m_pc + 32'd4;
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_known) begin
            check("model_pc",    PC,          m_pc);
            check("model_instr", IF_ID_instr, m_instr);
            check("model_npc",   IF_ID_NPC,   m_npc);
            check("model_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PCSrc = 0; stall = 0; flush = 0; imem_we = 0; EX_MEM_NPC = 32'h0;
    endtask

    task automatic expect4(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] npc, input logic v);
        check({tag, "_pc"},    PC,          pc);
        check({tag, "_instr"}, IF_ID_instr, ins);
        check({tag, "_npc"},   IF_ID_NPC,   npc);
        check({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, v});
    endtask

    initial begin
        rst_n = 0;
        idle();
        imem_waddr = 0; imem_wdata = 0;
        for (int i = 0; i < 128; i++) img[i] = $urandom;
        img[0] = 32'h00010000; img[1] = 32'h00430000;
        img[2] = 32'h00850000; img[3] = 32'h00C70000;

        // Load memory while held in reset.
        for (int i = 0; i < 128; i++) begin
            imem_we = 1; imem_waddr = i[6:0]; imem_wdata = img[i];
            edge1();
        end
        imem_we = 0;
        edge1(); edge1();
        expect4("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        // Sequential fetch.
        rst_n = 1;
        edge1(); expect4("seq1", 32'h4, 32'h00010000, 32'h4, 1'b1);
        edge1(); expect4("seq2", 32'h8, 32'h00430000, 32'h8, 1'b1);

        // Stall two cycles at PC=8.
        stall = 1;
        edge1(); expect4("stall1", 32'h8, 32'h00430000, 32'h8, 1'b1);
        edge1(); expect4("stall2", 32'h8, 32'h00430000, 32'h8, 1'b1);
        stall = 0;
        edge1(); expect4("unstall", 32'hC, 32'h00850000, 32'hC, 1'b1);

        // Branch with flush; target byte offset is dropped.
        PCSrc = 1; flush = 1; EX_MEM_NPC = 32'h00000006;
        edge1(); expect4("brflush", 32'h4, 32'h0, 32'h0, 1'b0);
        idle();
        edge1(); expect4("after_br", 32'h8, 32'h00430000, 32'h8, 1'b1);

        // All controls at once: redirect beats stall, flush beats stall.
        stall = 1; flush = 1; PCSrc = 1; EX_MEM_NPC = 32'h0;
        edge1(); expect4("prio", 32'h0, 32'h0, 32'h0, 1'b0);
        idle(); stall = 1;
        edge1(); expect4("prio_stall", 32'h0, 32'h0, 32'h0, 1'b0);
        idle();

        // Wrap and write collision on mem[127].
        PCSrc = 1; EX_MEM_NPC = 32'hFFFFFFFC;
        edge1(); expect4("to_top", 32'hFFFFFFFC, 32'h00010000, 32'h4, 1'b1);
        idle();
        imem_we = 1; imem_waddr = 7'd127; imem_wdata = ~img[127];
        edge1(); expect4("wrap", 32'h0, img[127], 32'h0, 1'b1);
        idle();
        PCSrc = 1; flush = 1; EX_MEM_NPC = 32'hFFFFFFFF;
        edge1(); expect4("to_top2", 32'hFFFFFFFC, 32'h0, 32'h0, 1'b0);
        idle();
        edge1(); expect4("refetch", 32'h0, ~img[127], 32'h0, 1'b1);

        // Reset during stall and flush clears everything.
        stall = 1; flush = 1; rst_n = 0;
        edge1(); expect4("rst_prio", 32'h0, 32'h0, 32'h0, 1'b0);
        rst_n = 1; idle();

        // Randomized traffic, checked by the every-cycle compare.
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            PCSrc   = ($urandom_range(0, 9) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            flush   = ($urandom_range(0, 4) == 0);
            imem_we = ($urandom_range(0, 3) == 0);
            imem_waddr = ($urandom_range(0, 1) == 0) ? PC[8:2] : 7'($urandom);
            imem_wdata = $urandom;
            EX_MEM_NPC = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            edge1();
        end
        idle();
        edge1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
